// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state type and
// the byte-enable helper used by the store path.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

    // Halfword lanes depend only on addr[1], so a forced-aligned address needs no extra masking.
    function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] addr);
        logic [3:0] be;
        be = 4'b0000;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr;
            2'b01:   be = addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_be.sv
// Word-organised data RAM with per-byte write enables; synchronous write,
// combinational read. Contents are deliberately not reset.
module dmem_be #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit with integrated byte-lane data memory, configurable wait states
// and fault detection. Define LSU_MISALIGN_TRAP_EN to fault on misaligned h/w accesses.
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    lsu_state_t  state, state_next;
    logic [3:0]  wait_cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;

    logic        cur_we;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr, cur_wdata, offset;
    logic        accept, enter_resp, fault, bad_f3, out_of_range, misalign;
    logic        mem_we;
    logic [31:0] mem_rdata, store_data, load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // With zero wait states RESP is entered on the accept edge, so decode must see the live request.
    assign cur_we    = (state == IDLE) ? req_we     : we_q;
    assign cur_f3    = (state == IDLE) ? req_funct3 : f3_q;
    assign cur_addr  = (state == IDLE) ? req_addr   : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata  : wdata_q;

    assign offset       = cur_addr - ADDR_BASE;
    assign out_of_range = offset >= (32'(DEPTH_WORDS) << 2);
    assign accept       = (state == IDLE) && req_valid;
    assign rsp_valid    = (state == RESP);

    always_comb begin
        bad_f3   = 1'b0;
        misalign = 1'b0;
        if (cur_we) bad_f3 = (cur_f3 >= 3'b011);
        else        bad_f3 = !(cur_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
`ifdef LSU_MISALIGN_TRAP_EN
        case (cur_f3)
            F3_H, F3_HU: misalign = offset[0];
            F3_W:        misalign = |offset[1:0];
            default:     misalign = 1'b0;
        endcase
`endif
        fault = bad_f3 || out_of_range || misalign;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = (WAIT_STATES > 0) ? ACCESS : RESP;
            end
            ACCESS:  if (wait_cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP) && (state != RESP);
    assign mem_we     = enter_resp && cur_we && !fault && !reset;

    always_comb begin
        case (cur_f3[1:0])
            2'b00:   store_data = {4{cur_wdata[7:0]}};
            2'b01:   store_data = {2{cur_wdata[15:0]}};
            default: store_data = cur_wdata;
        endcase
    end

    dmem_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (be_for(cur_f3, offset[1:0])),
        .addr  (offset[AW+1:2]),
        .wdata (store_data),
        .rdata (mem_rdata)
    );

    always_comb begin
        case (offset[1:0])
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel  = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = '0;
        if (!cur_we && !fault) begin
            case (cur_f3)
                F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
                F3_BU:   load_data = {24'h0, byte_sel};
                F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
                F3_HU:   load_data = {16'h0, half_sel};
                F3_W:    load_data = mem_rdata;
                default: load_data = '0;
            endcase
        end
    end

    // Response data is latched on entry to RESP and held until the next response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q     <= req_we;
                f3_q     <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                wait_cnt <= WAIT_INIT;
            end else if (state == ACCESS && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_rdata <= load_data;
                rsp_fault <= fault;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed testbench for lsu_dmem: two instances (0 and 3 wait states) exercised
// with hand-computed vectors. Honours LSU_MISALIGN_TRAP_EN for misalignment cases.
module tb_lsu_dmem;

    logic        clk;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_fault  [2];

    int waits [2] = '{0, 3};
    int passed = 0;
    int total  = 0;

    lsu_dmem #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_BASE(32'h0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0])
    );

    lsu_dmem #(.DEPTH_WORDS(256), .WAIT_STATES(3), .ADDR_BASE(32'h0)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full transaction; ok drops if req_ready rises early or rsp_valid lasts more than one cycle.
    task automatic do_req(input int w, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic fault,
                          output int lat, output logic ok);
        @(negedge clk);
        req_valid[w]  = 1'b1;
        req_we[w]     = we;
        req_funct3[w] = f3;
        req_addr[w]   = addr;
        req_wdata[w]  = wdata;
        @(posedge clk);
        #1;
        req_valid[w] = 1'b0;
        lat = 0;
        ok  = 1'b1;
        while (rsp_valid[w] !== 1'b1 && lat < 40) begin
            if (req_ready[w] !== 1'b0) ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (rsp_valid[w] !== 1'b1) ok = 1'b0;
        if (req_ready[w] !== 1'b0) ok = 1'b0;
        rdata = rsp_rdata[w];
        fault = rsp_fault[w];
        @(posedge clk);
        #1;
        if (rsp_valid[w] !== 1'b0 || req_ready[w] !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        for (int w = 0; w < 2; w++) begin
            total++;
            if (req_ready[w] !== 1'b1) $display("[TB] FAIL reset_ready w=%0d: got %b, expected 1", waits[w], req_ready[w]);
            else passed++;
            total++;
            if (rsp_valid[w] !== 1'b0) $display("[TB] FAIL reset_valid w=%0d: got %b, expected 0", waits[w], rsp_valid[w]);
            else passed++;
            total++;
            if (rsp_rdata[w] !== 32'h0 || rsp_fault[w] !== 1'b0)
                $display("[TB] FAIL reset_rsp w=%0d: got rdata=%h fault=%b, expected 0/0", waits[w], rsp_rdata[w], rsp_fault[w]);
            else passed++;
        end
    endtask

    task automatic test_word(input int w);
        logic [31:0] rd;
        logic        flt, ok;
        int          lat;
        do_req(w, 1'b1, 3'b010, 32'h64, 32'hDEADBEEF, rd, flt, lat, ok);
        total++;
        if (flt !== 1'b0 || rd !== 32'h0 || !ok || lat != waits[w])
            $display("[TB] FAIL sw_word w=%0d: got fault=%b rdata=%h lat=%0d ok=%b, expected 0/0/%0d/1", waits[w], flt, rd, lat, ok, waits[w]);
        else passed++;
        do_req(w, 1'b0, 3'b010, 32'h64, 32'h0, rd, flt, lat, ok);
        total++;
        if (rd !== 32'hDEADBEEF || flt !== 1'b0)
            $display("[TB] FAIL lw_word w=%0d: got rdata=%h fault=%b, expected deadbeef/0", waits[w], rd, flt);
        else passed++;
        total++;
        if (!ok || lat != waits[w])
            $display("[TB] FAIL lw_timing w=%0d: got lat=%0d ok=%b, expected lat=%0d ok=1", waits[w], lat, ok, waits[w]);
        else passed++;
    endtask

    task automatic test_subword(input int w);
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h67, 32'h67, 32'h66, 32'h64};
        logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        logic [31:0] rd;
        logic        flt, ok;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            do_req(w, 1'b0, f3s[i], adrs[i], 32'h0, rd, flt, lat, ok);
            total++;
            if (rd !== exps[i] || flt !== 1'b0 || !ok)
                $display("[TB] FAIL subword_load%0d w=%0d: got rdata=%h fault=%b ok=%b, expected %h/0/1", i, waits[w], rd, flt, ok, exps[i]);
            else passed++;
        end
        do_req(w, 1'b1, 3'b000, 32'h65, 32'h00000012, rd, flt, lat, ok);
        do_req(w, 1'b0, 3'b010, 32'h64, 32'h0, rd, flt, lat, ok);
        total++;
        if (rd !== 32'hDEAD12EF)
            $display("[TB] FAIL sb_merge w=%0d: got %h, expected deadbeef with lane1=12 (dead12ef)", waits[w], rd);
        else passed++;
        do_req(w, 1'b1, 3'b001, 32'h6A, 32'hFFFF5A5A, rd, flt, lat, ok);
        do_req(w, 1'b0, 3'b010, 32'h68, 32'h0, rd, flt, lat, ok);
        total++;
        if (rd[31:16] !== 16'h5A5A)
            $display("[TB] FAIL sh_upper w=%0d: got %h, expected upper half 5a5a", waits[w], rd);
        else passed++;
    endtask

    task automatic test_fault(input int w);
        logic [31:0] rd;
        logic        flt, ok;
        int          lat;
        do_req(w, 1'b1, 3'b010, 32'h0, 32'h01234567, rd, flt, lat, ok);
        do_req(w, 1'b0, 3'b010, 32'h400, 32'h0, rd, flt, lat, ok);
        total++;
        if (flt !== 1'b1 || rd !== 32'h0 || !ok || lat != waits[w])
            $display("[TB] FAIL lw_oob w=%0d: got fault=%b rdata=%h lat=%0d, expected 1/0/%0d", waits[w], flt, rd, lat, waits[w]);
        else passed++;
        total++;
        if (rsp_fault[w] !== 1'b1 || rsp_rdata[w] !== 32'h0)
            $display("[TB] FAIL fault_hold w=%0d: got fault=%b rdata=%h, expected 1/0", waits[w], rsp_fault[w], rsp_rdata[w]);
        else passed++;
        do_req(w, 1'b1, 3'b010, 32'h400, 32'h55, rd, flt, lat, ok);
        total++;
        if (flt !== 1'b1)
            $display("[TB] FAIL sw_oob w=%0d: got fault=%b, expected 1", waits[w], flt);
        else passed++;
        do_req(w, 1'b0, 3'b010, 32'h0, 32'h0, rd, flt, lat, ok);
        total++;
        if (rd !== 32'h01234567 || flt !== 1'b0)
            $display("[TB] FAIL no_alias w=%0d: got rdata=%h fault=%b, expected 01234567/0", waits[w], rd, flt);
        else passed++;
        do_req(w, 1'b0, 3'b011, 32'h64, 32'h0, rd, flt, lat, ok);
        total++;
        if (flt !== 1'b1 || rd !== 32'h0)
            $display("[TB] FAIL ld_f3_011 w=%0d: got fault=%b rdata=%h, expected 1/0", waits[w], flt, rd);
        else passed++;
        do_req(w, 1'b1, 3'b100, 32'h0, 32'hFFFFFFFF, rd, flt, lat, ok);
        do_req(w, 1'b0, 3'b010, 32'h0, 32'h0, rd, flt, lat, ok);
        total++;
        if (rd !== 32'h01234567)
            $display("[TB] FAIL st_f3_100 w=%0d: got word %h, expected 01234567", waits[w], rd);
        else passed++;
    endtask

    task automatic test_misalign(input int w);
        logic [31:0] rd;
        logic        flt, ok;
        int          lat;
        logic        exp_flt;
        logic [31:0] exp_rd, exp_word;
`ifdef LSU_MISALIGN_TRAP_EN
        exp_flt  = 1'b1;
        exp_rd   = 32'h0;
        exp_word = 32'hDEAD12EF;
`else
        exp_flt  = 1'b0;
        exp_rd   = 32'hDEAD12EF;
        exp_word = 32'hCAFEF00D;
`endif
        do_req(w, 1'b0, 3'b010, 32'h66, 32'h0, rd, flt, lat, ok);
        total++;
        if (flt !== exp_flt || rd !== exp_rd)
            $display("[TB] FAIL lw_misalign w=%0d: got fault=%b rdata=%h, expected %b/%h", waits[w], flt, rd, exp_flt, exp_rd);
        else passed++;
        do_req(w, 1'b1, 3'b010, 32'h66, 32'hCAFEF00D, rd, flt, lat, ok);
        total++;
        if (flt !== exp_flt)
            $display("[TB] FAIL sw_misalign w=%0d: got fault=%b, expected %b", waits[w], flt, exp_flt);
        else passed++;
        do_req(w, 1'b0, 3'b010, 32'h64, 32'h0, rd, flt, lat, ok);
        total++;
        if (rd !== exp_word)
            $display("[TB] FAIL misalign_word w=%0d: got %h, expected %h", waits[w], rd, exp_word);
        else passed++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic        flt, ok;
        int          lat;
        int          seen;
        do_req(1, 1'b1, 3'b010, 32'h10, 32'h22, rd, flt, lat, ok);
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b1;
        req_funct3[1] = 3'b010;
        req_addr[1]   = 32'h10;
        req_wdata[1]  = 32'h11;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (req_ready[1] !== 1'b1)
            $display("[TB] FAIL abort_ready: got %b, expected 1", req_ready[1]);
        else passed++;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid[1] === 1'b1) seen++;
        end
        total++;
        if (seen != 0)
            $display("[TB] FAIL abort_no_rsp: got %0d rsp_valid cycles, expected 0", seen);
        else passed++;
        do_req(1, 1'b0, 3'b010, 32'h10, 32'h0, rd, flt, lat, ok);
        total++;
        if (rd !== 32'h22 || flt !== 1'b0)
            $display("[TB] FAIL abort_no_write: got rdata=%h fault=%b, expected 00000022/0", rd, flt);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        for (int w = 0; w < 2; w++) begin
            req_valid[w]  = 1'b0;
            req_we[w]     = 1'b0;
            req_funct3[w] = 3'b000;
            req_addr[w]   = 32'h0;
            req_wdata[w]  = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        test_reset();
        for (int w = 0; w < 2; w++) begin
            test_word(w);
            test_subword(w);
            test_fault(w);
            test_misalign(w);
        end
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
